ysyx_24100006_xbar: RTL and testbench
=====================================

# ysyx_24100006_xbar

AXI-Lite 1-to-2 crossbar placed directly upstream of the UART and SRAM slaves. It takes the MEM stage's single AXI-Lite master port, decodes each request address, and routes the whole transaction to the UART slave or the SRAM slave. Addresses that hit neither window are completed locally with a DECERR response. It allows exactly one outstanding transaction at a time.

## Interface
Parameters:
- SRAM_BASE, 32'h8000_0000, base of the SRAM window
- SRAM_SIZE, 32'h0800_0000, size of the SRAM window in bytes
- UART_BASE, 32'ha000_03f8, base of the UART window (fixed size 8 bytes)

Ports:
- clk  in  1  single clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-low reset
- m_araddr  in  32  read address from MEM
- m_arvalid / m_arready  in / out  1  read-address handshake
- m_rdata  out  32  read data to MEM
- m_rresp  out  2  read response to MEM
- m_rvalid / m_rready  out / in  1  read-data handshake
- m_awaddr  in  32  write address
- m_awvalid / m_awready  in / out  1  write-address handshake
- m_wdata  in  32  write data
- m_bytes  in  8  write byte mask / size, forwarded unchanged
- m_wvalid / m_wready  in / out  1  write-data handshake
- m_bresp  out  2  write response
- m_bvalid / m_bready  out / in  1  write-response handshake
- s0_* (SRAM) and s1_* (UART): each carries the same 17 signals with the same widths and the opposite direction (araddr, arvalid, arready, rdata, rresp, rvalid, rready, awaddr, awvalid, awready, wdata, bytes, wvalid, wready, bresp, bvalid, bready).

## Operation
- Decode rule: an address is in a window iff (addr − BASE) mod 2^32 < SIZE, using unsigned 32-bit subtraction. UART is checked first, then SRAM; otherwise the address is a decode error.
- States: IDLE, RD, WR, ERR_RA, ERR_RD, ERR_WA, ERR_WB. A registered `sel` holds the target slave.
- IDLE:
  - If m_arvalid: decode m_araddr and go to RD, or to ERR_RA on a miss.
  - Else if m_awvalid && m_wvalid: decode m_awaddr and go to WR, or to ERR_WA on a miss.
  - Reads have priority over writes.
  - All m_* ready/valid outputs are 0 in IDLE.
- RD: AR and R channels are connected combinationally to the selected slave.
  - s_arvalid = m_arvalid and s_rready = m_rready.
  - m_arready, m_rvalid, m_rdata and m_rresp come from the selected slave.
  - Leave for IDLE on m_rvalid && m_rready.
- WR: AW, W and B channels are connected the same way to the selected slave. Leave for IDLE on m_bvalid && m_bready.
- Unselected slave: all its valid/ready inputs are held 0. Address, data and bytes are broadcast to both slaves.
- Slave responses, including UART rresp 01, pass through unmodified.
- ERR_RA: m_arready = 1 for one cycle, then go to ERR_RD.
- ERR_RD: m_rvalid = 1, m_rresp = 2'b11, m_rdata = 0, held until m_rready; then go to IDLE.
- ERR_WA: m_awready = m_wready = 1 for one cycle, then go to ERR_WB.
- ERR_WB: m_bvalid = 1, m_bresp = 2'b11, held until m_bready; then go to IDLE.
- Outside RD/ERR_RD, m_rdata and m_rresp are 0. Outside WR/ERR_WB, m_bresp is 0.

## Timing
- Reset low: state goes to IDLE and sel to 0 immediately, without waiting for a clock edge. Every m_* and s_* valid/ready output is 0 while reset is low. All data/resp outputs are 0.
- Reset mid-transaction: the transaction is abandoned and no response is delivered. Slaves see their valids drop.
- Decode costs exactly one cycle: the request is sampled in IDLE and forwarded from the next cycle.
- Forwarding adds zero cycles: ready, valid and response signals are combinational paths through the crossbar.
- After each completed response the block spends one IDLE cycle, so back-to-back requests are spaced at least two cycles apart plus the slave latency.
- The master must hold address, data and valid stable until the corresponding ready handshake.

## Test plan
- Write wdata 0x41 to 0xa000_03f8 → s1_awvalid and s1_wvalid assert one cycle later; all s0 valids stay 0; m_bresp 00 and m_bvalid are forwarded; state returns to IDLE.
- Read 0x8000_0010 with s0 returning 0xdeadbeef / 00 → m_rdata 0xdeadbeef, m_rresp 00; s1_arvalid never asserts.
- Read 0xa000_03fc with s1 returning rresp 01, rdata 0 → m_rresp 01 forwarded unmodified.
- Read 0x0000_1000 with m_rready low for 3 cycles → no s_* valid asserts; m_arready pulses for 1 cycle; m_rvalid=1, rresp 11, rdata 0 held steady until m_rready.
- m_arvalid and m_awvalid/m_wvalid raised in the same cycle, both to 0x8000_0000 → read completes first, then the write starts after one IDLE cycle.
- Boundaries:
  - 0xa000_0400 → decode error.
  - 0x87ff_fffc → s0.
  - 0x8800_0000 → decode error.
  - Reset driven low while in RD waiting on s0_rvalid → all m_* valid/ready outputs are 0 at once; after reset releases, a fresh read is accepted normally.

Source files
------------

// File: rtl/ysyx_24100006_xbar.sv
// rtl/ysyx_24100006_xbar.sv - AXI-Lite 1-to-2 crossbar routing MEM requests to SRAM (s0) or UART (s1)
module ysyx_24100006_xbar #(
    parameter logic [31:0] SRAM_BASE = 32'h8000_0000,
    parameter logic [31:0] SRAM_SIZE = 32'h0800_0000,
    parameter logic [31:0] UART_BASE = 32'ha000_03f8
) (
    input  logic        clk,
    input  logic        reset,

    // master port from MEM
    input  logic [31:0] m_araddr,
    input  logic        m_arvalid,
    output logic        m_arready,
    output logic [31:0] m_rdata,
    output logic [1:0]  m_rresp,
    output logic        m_rvalid,
    input  logic        m_rready,
    input  logic [31:0] m_awaddr,
    input  logic        m_awvalid,
    output logic        m_awready,
    input  logic [31:0] m_wdata,
    input  logic [7:0]  m_bytes,
    input  logic        m_wvalid,
    output logic        m_wready,
    output logic [1:0]  m_bresp,
    output logic        m_bvalid,
    input  logic        m_bready,

    // slave 0: SRAM
    output logic [31:0] s0_araddr,
    output logic        s0_arvalid,
    input  logic        s0_arready,
    input  logic [31:0] s0_rdata,
    input  logic [1:0]  s0_rresp,
    input  logic        s0_rvalid,
    output logic        s0_rready,
    output logic [31:0] s0_awaddr,
    output logic        s0_awvalid,
    input  logic        s0_awready,
    output logic [31:0] s0_wdata,
    output logic [7:0]  s0_bytes,
    output logic        s0_wvalid,
    input  logic        s0_wready,
    input  logic [1:0]  s0_bresp,
    input  logic        s0_bvalid,
    output logic        s0_bready,

    // slave 1: UART
    output logic [31:0] s1_araddr,
    output logic        s1_arvalid,
    input  logic        s1_arready,
    input  logic [31:0] s1_rdata,
    input  logic [1:0]  s1_rresp,
    input  logic        s1_rvalid,
    output logic        s1_rready,
    output logic [31:0] s1_awaddr,
    output logic        s1_awvalid,
    input  logic        s1_awready,
    output logic [31:0] s1_wdata,
    output logic [7:0]  s1_bytes,
    output logic        s1_wvalid,
    input  logic        s1_wready,
    input  logic [1:0]  s1_bresp,
    input  logic        s1_bvalid,
    output logic        s1_bready
);

    localparam logic [31:0] UART_SIZE = 32'd8;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_RD     = 3'd1;
    localparam logic [2:0] ST_WR     = 3'd2;
    localparam logic [2:0] ST_ERR_RA = 3'd3;
    localparam logic [2:0] ST_ERR_RD = 3'd4;
    localparam logic [2:0] ST_ERR_WA = 3'd5;
    localparam logic [2:0] ST_ERR_WB = 3'd6;

    localparam logic SEL_SRAM = 1'b0;
    localparam logic SEL_UART = 1'b1;

    localparam logic [1:0] RESP_DECERR = 2'b11;

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic       sel;
    logic       sel_nxt;
    logic [1:0] ar_dec;
    logic [1:0] aw_dec;

    // Returns {hit, target}. Unsigned wrap-around subtraction makes each window
    // a single compare; UART is tested first so it wins any overlap.
    function automatic logic [1:0] decode(input logic [31:0] addr);
        logic [31:0] uart_off;
        logic [31:0] sram_off;
        uart_off = addr - UART_BASE;
        sram_off = addr - SRAM_BASE;
        if (uart_off < UART_SIZE) begin
            decode = {1'b1, SEL_UART};
        end else if (sram_off < SRAM_SIZE) begin
            decode = {1'b1, SEL_SRAM};
        end else begin
            decode = 2'b00;
        end
    endfunction

    assign ar_dec = decode(m_araddr);
    assign aw_dec = decode(m_awaddr);

    // Transaction sequencing: one outstanding request, reads win ties.
    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        case (state)
            ST_IDLE: begin
                if (m_arvalid) begin
                    if (ar_dec[1]) begin
                        state_nxt = ST_RD;
                        sel_nxt   = ar_dec[0];
                    end else begin
                        state_nxt = ST_ERR_RA;
                    end
                end else if (m_awvalid && m_wvalid) begin
                    if (aw_dec[1]) begin
                        state_nxt = ST_WR;
                        sel_nxt   = aw_dec[0];
                    end else begin
                        state_nxt = ST_ERR_WA;
                    end
                end
            end
            ST_RD: begin
                if (m_rvalid && m_rready) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_WR: begin
                if (m_bvalid && m_bready) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_ERR_RA: state_nxt = ST_ERR_RD;
            ST_ERR_RD: begin
                if (m_rready) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_ERR_WA: state_nxt = ST_ERR_WB;
            ST_ERR_WB: begin
                if (m_bready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State and target registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            sel   <= SEL_SRAM;
        end else begin
            state <= state_nxt;
            sel   <= sel_nxt;
        end
    end

    // Channel steering: everything is gated by reset so no handshake or data
    // can leak out while reset is held low, even before the first clock edge.
    always_comb begin
        m_arready  = 1'b0;
        m_rdata    = 32'd0;
        m_rresp    = 2'b00;
        m_rvalid   = 1'b0;
        m_awready  = 1'b0;
        m_wready   = 1'b0;
        m_bresp    = 2'b00;
        m_bvalid   = 1'b0;

        s0_araddr  = 32'd0;
        s0_arvalid = 1'b0;
        s0_rready  = 1'b0;
        s0_awaddr  = 32'd0;
        s0_awvalid = 1'b0;
        s0_wdata   = 32'd0;
        s0_bytes   = 8'd0;
        s0_wvalid  = 1'b0;
        s0_bready  = 1'b0;

        s1_araddr  = 32'd0;
        s1_arvalid = 1'b0;
        s1_rready  = 1'b0;
        s1_awaddr  = 32'd0;
        s1_awvalid = 1'b0;
        s1_wdata   = 32'd0;
        s1_bytes   = 8'd0;
        s1_wvalid  = 1'b0;
        s1_bready  = 1'b0;

        if (reset) begin
            // Payloads go to both slaves; only the valids select one.
            s0_araddr = m_araddr;
            s0_awaddr = m_awaddr;
            s0_wdata  = m_wdata;
            s0_bytes  = m_bytes;
            s1_araddr = m_araddr;
            s1_awaddr = m_awaddr;
            s1_wdata  = m_wdata;
            s1_bytes  = m_bytes;

            case (state)
                ST_RD: begin
                    if (sel == SEL_UART) begin
                        s1_arvalid = m_arvalid;
                        s1_rready  = m_rready;
                        m_arready  = s1_arready;
                        m_rvalid   = s1_rvalid;
                        m_rdata    = s1_rdata;
                        m_rresp    = s1_rresp;
                    end else begin
                        s0_arvalid = m_arvalid;
                        s0_rready  = m_rready;
                        m_arready  = s0_arready;
                        m_rvalid   = s0_rvalid;
                        m_rdata    = s0_rdata;
                        m_rresp    = s0_rresp;
                    end
                end
                ST_WR: begin
                    if (sel == SEL_UART) begin
                        s1_awvalid = m_awvalid;
                        s1_wvalid  = m_wvalid;
                        s1_bready  = m_bready;
                        m_awready  = s1_awready;
                        m_wready   = s1_wready;
                        m_bvalid   = s1_bvalid;
                        m_bresp    = s1_bresp;
                    end else begin
                        s0_awvalid = m_awvalid;
                        s0_wvalid  = m_wvalid;
                        s0_bready  = m_bready;
                        m_awready  = s0_awready;
                        m_wready   = s0_wready;
                        m_bvalid   = s0_bvalid;
                        m_bresp    = s0_bresp;
                    end
                end
                ST_ERR_RA: begin
                    m_arready = 1'b1;
                end
                ST_ERR_RD: begin
                    m_rvalid = 1'b1;
                    m_rresp  = RESP_DECERR;
                end
                ST_ERR_WA: begin
                    m_awready = 1'b1;
                    m_wready  = 1'b1;
                end
                ST_ERR_WB: begin
                    m_bvalid = 1'b1;
                    m_bresp  = RESP_DECERR;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_24100006_xbar.sv
// tb/tb_ysyx_24100006_xbar.sv - self-checking bench for ysyx_24100006_xbar
module tb_ysyx_24100006_xbar;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] m_araddr = 32'd0, m_awaddr = 32'd0, m_wdata = 32'd0;
    logic [7:0]  m_bytes = 8'd0;
    logic        m_arvalid = 1'b0, m_rready = 1'b0, m_awvalid = 1'b0, m_wvalid = 1'b0, m_bready = 1'b0;
    logic        m_arready, m_rvalid, m_awready, m_wready, m_bvalid;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp, m_bresp;

    logic [31:0] s0_araddr, s1_araddr, s0_awaddr, s1_awaddr, s0_wdata, s1_wdata;
    logic [7:0]  s0_bytes, s1_bytes;
    logic        s0_arvalid, s0_rready, s0_awvalid, s0_wvalid, s0_bready;
    logic        s1_arvalid, s1_rready, s1_awvalid, s1_wvalid, s1_bready;

    logic [1:0]  s_arready, s_rvalid, s_awready, s_wready, s_bvalid;
    logic [31:0] s_rdata [2];
    logic [1:0]  s_rresp [2];
    logic [1:0]  s_bresp [2];

    ysyx_24100006_xbar dut (
        .clk(clk), .reset(reset),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_bytes(m_bytes), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .s0_araddr(s0_araddr), .s0_arvalid(s0_arvalid), .s0_arready(s_arready[0]),
        .s0_rdata(s_rdata[0]), .s0_rresp(s_rresp[0]), .s0_rvalid(s_rvalid[0]), .s0_rready(s0_rready),
        .s0_awaddr(s0_awaddr), .s0_awvalid(s0_awvalid), .s0_awready(s_awready[0]),
        .s0_wdata(s0_wdata), .s0_bytes(s0_bytes), .s0_wvalid(s0_wvalid), .s0_wready(s_wready[0]),
        .s0_bresp(s_bresp[0]), .s0_bvalid(s_bvalid[0]), .s0_bready(s0_bready),
        .s1_araddr(s1_araddr), .s1_arvalid(s1_arvalid), .s1_arready(s_arready[1]),
        .s1_rdata(s_rdata[1]), .s1_rresp(s_rresp[1]), .s1_rvalid(s_rvalid[1]), .s1_rready(s1_rready),
        .s1_awaddr(s1_awaddr), .s1_awvalid(s1_awvalid), .s1_awready(s_awready[1]),
        .s1_wdata(s1_wdata), .s1_bytes(s1_bytes), .s1_wvalid(s1_wvalid), .s1_wready(s_wready[1]),
        .s1_bresp(s_bresp[1]), .s1_bvalid(s_bvalid[1]), .s1_bready(s1_bready)
    );

    // slave-side views, index 0 = SRAM, 1 = UART
    logic [1:0]        sv_arvalid, sv_rready, sv_awvalid, sv_wvalid, sv_bready;
    logic [1:0][31:0]  sv_araddr, sv_awaddr, sv_wdata;
    logic [1:0][7:0]   sv_bytes;
    assign sv_arvalid = {s1_arvalid, s0_arvalid};
    assign sv_rready  = {s1_rready, s0_rready};
    assign sv_awvalid = {s1_awvalid, s0_awvalid};
    assign sv_wvalid  = {s1_wvalid, s0_wvalid};
    assign sv_bready  = {s1_bready, s0_bready};
    assign sv_araddr  = {s1_araddr, s0_araddr};
    assign sv_awaddr  = {s1_awaddr, s0_awaddr};
    assign sv_wdata   = {s1_wdata, s0_wdata};
    assign sv_bytes   = {s1_bytes, s0_bytes};

    // slave models: memory holds data ^ ~addr so an unwritten word reads as ~addr
    bit              rnd_mode = 1'b0;
    int              lat_fix = 0;
    logic [1:0]      acc, rpend, bpend;
    logic [1:0][2:0] rcnt, bcnt;
    logic [1:0][31:0] rd_q, last_wa, last_wd;
    logic [1:0][1:0] rr_q;
    logic [1:0][7:0] last_wb;
    bit [31:0]       smem [2][64];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc   <= 2'b11;
            rpend <= 2'b00;
            bpend <= 2'b00;
            rcnt  <= '0;
            bcnt  <= '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                acc[k] <= rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
                if (sv_arvalid[k] && s_arready[k]) begin
                    rpend[k] <= 1'b1;
                    rcnt[k]  <= rnd_mode ? 3'($urandom_range(0, 3)) : 3'(lat_fix);
                    if (k == 1 && sv_araddr[k][2]) begin
                        rd_q[k] <= 32'd0;
                        rr_q[k] <= 2'b01;
                    end else begin
                        rd_q[k] <= smem[k][sv_araddr[k][7:2]] ^ ~sv_araddr[k];
                        rr_q[k] <= 2'b00;
                    end
                end else if (s_rvalid[k] && sv_rready[k]) begin
                    rpend[k] <= 1'b0;
                end else if (rpend[k] && rcnt[k] != 3'd0) begin
                    rcnt[k] <= rcnt[k] - 3'd1;
                end
                if (sv_awvalid[k] && s_awready[k]) begin
                    smem[k][sv_awaddr[k][7:2]] <= sv_wdata[k] ^ ~sv_awaddr[k];
                    last_wa[k] <= sv_awaddr[k];
                    last_wd[k] <= sv_wdata[k];
                    last_wb[k] <= sv_bytes[k];
                    bpend[k]   <= 1'b1;
                    bcnt[k]    <= rnd_mode ? 3'($urandom_range(0, 3)) : 3'(lat_fix);
                end else if (s_bvalid[k] && sv_bready[k]) begin
                    bpend[k] <= 1'b0;
                end else if (bpend[k] && bcnt[k] != 3'd0) begin
                    bcnt[k] <= bcnt[k] - 3'd1;
                end
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            s_arready[k] = sv_arvalid[k] & acc[k];
            s_awready[k] = sv_awvalid[k] & sv_wvalid[k] & acc[k];
            s_wready[k]  = s_awready[k];
            s_rvalid[k]  = rpend[k] && (rcnt[k] == 3'd0);
            s_rdata[k]   = s_rvalid[k] ? rd_q[k] : 32'd0;
            s_rresp[k]   = s_rvalid[k] ? rr_q[k] : 2'b00;
            s_bvalid[k]  = bpend[k] && (bcnt[k] == 3'd0);
            s_bresp[k]   = 2'b00;
        end
    end

    // activity counters: cycles in which each slave saw any valid/ready from the crossbar
    int vc0 = 0, vc1 = 0;
    always @(negedge clk) begin
        if (s0_arvalid | s0_rready | s0_awvalid | s0_wvalid | s0_bready) vc0 <= vc0 + 1;
        if (s1_arvalid | s1_rready | s1_awvalid | s1_wvalid | s1_bready) vc1 <= vc1 + 1;
    end

    int n_cmp = 0, n_bad = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: address map as plain ranges, memory keyed by full address
    logic [31:0] ref_mem [logic [31:0]];

    function automatic int ref_target(input logic [31:0] a);
        longint unsigned x;
        x = {32'd0, a};
        if (x >= 64'hA000_03F8 && x < 64'hA000_0400) return 1;
        if (x >= 64'h8000_0000 && x < 64'h8800_0000) return 0;
        return -1;
    endfunction

    task automatic ref_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
        int t;
        t = ref_target(a);
        if (t < 0) begin
            d = 32'd0; r = 2'b11;
        end else if (t == 1 && a[2]) begin
            d = 32'd0; r = 2'b01;
        end else begin
            d = ref_mem.exists(a) ? ref_mem[a] : ~a; r = 2'b00;
        end
    endtask

    task automatic ref_write(input logic [31:0] a, input logic [31:0] d, output logic [1:0] r);
        if (ref_target(a) < 0) begin
            r = 2'b11;
        end else begin
            ref_mem[a] = d;
            r = 2'b00;
        end
    endtask

    // master transactions; start at posedge+1, return at posedge+1 after completion
    task automatic do_read(input logic [31:0] addr, input bit rnd,
                           output logic [31:0] data, output logic [1:0] resp, output int lat);
        int n;
        bit done;
        m_araddr = addr; m_arvalid = 1'b1; data = 32'd0; resp = 2'b00;
        n = 0; done = 1'b0;
        while (!done && n < 60) begin
            @(negedge clk); n++;
            if (m_arready) done = 1'b1;
        end
        lat = n;
        chk("ar_handshake", 32'(done), 32'd1);
        @(posedge clk); #1 m_arvalid = 1'b0;
        if (done) begin
            n = 0; done = 1'b0;
            while (!done && n < 60) begin
                @(negedge clk);
                m_rready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                #1 n++;
                if (m_rvalid && m_rready) begin
                    data = m_rdata; resp = m_rresp; done = 1'b1;
                end
            end
            chk("r_handshake", 32'(done), 32'd1);
            @(posedge clk); #1 m_rready = 1'b0;
        end
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [7:0] be,
                            input bit rnd, output logic [1:0] resp, output int lat);
        int n;
        bit done;
        m_awaddr = addr; m_wdata = data; m_bytes = be;
        m_awvalid = 1'b1; m_wvalid = 1'b1; resp = 2'b00;
        n = 0; done = 1'b0;
        while (!done && n < 60) begin
            @(negedge clk); n++;
            if (m_awready && m_wready) done = 1'b1;
        end
        lat = n;
        chk("aw_w_handshake", 32'(done), 32'd1);
        @(posedge clk); #1 m_awvalid = 1'b0; m_wvalid = 1'b0;
        if (done) begin
            n = 0; done = 1'b0;
            while (!done && n < 60) begin
                @(negedge clk);
                m_bready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                #1 n++;
                if (m_bvalid && m_bready) begin
                    resp = m_bresp; done = 1'b1;
                end
            end
            chk("b_handshake", 32'(done), 32'd1);
            @(posedge clk); #1 m_bready = 1'b0;
        end
    endtask

    function automatic logic [31:0] hs_vec();
        return {19'd0, m_arready, m_rvalid, m_awready, m_wready, m_bvalid,
                s0_arvalid, s0_rready, s0_awvalid, s0_wvalid, s0_bready,
                s1_arvalid, s1_rready, s1_awvalid, s1_wvalid, s1_bready};
    endfunction

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [7:0]  bytes;
        logic [1:0]  resp;
        logic [31:0] rdata;
        int          slave;
    } vec_t;

    vec_t tbl [14];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] d, ed, a, wd;
        logic [1:0]  r, er;
        logic [7:0]  be;
        int lat, v0, v1, t, cls;
        bit wr;

        tbl[0]  = '{1'b1, 32'ha000_03f8, 32'h0000_0041, 8'h01, 2'b00, 32'd0, 1};
        tbl[1]  = '{1'b1, 32'h8000_0010, 32'hdead_beef, 8'h0f, 2'b00, 32'd0, 0};
        tbl[2]  = '{1'b0, 32'h8000_0010, 32'd0, 8'h00, 2'b00, 32'hdead_beef, 0};
        tbl[3]  = '{1'b0, 32'ha000_03fc, 32'd0, 8'h00, 2'b01, 32'h0000_0000, 1};
        tbl[4]  = '{1'b0, 32'h0000_1000, 32'd0, 8'h00, 2'b11, 32'h0000_0000, -1};
        tbl[5]  = '{1'b0, 32'ha000_0400, 32'd0, 8'h00, 2'b11, 32'h0000_0000, -1};
        tbl[6]  = '{1'b1, 32'h87ff_fffc, 32'h1234_5678, 8'hf0, 2'b00, 32'd0, 0};
        tbl[7]  = '{1'b0, 32'h87ff_fffc, 32'd0, 8'h00, 2'b00, 32'h1234_5678, 0};
        tbl[8]  = '{1'b0, 32'h8800_0000, 32'd0, 8'h00, 2'b11, 32'h0000_0000, -1};
        tbl[9]  = '{1'b1, 32'h0000_0000, 32'hcafe_f00d, 8'hff, 2'b11, 32'd0, -1};
        tbl[10] = '{1'b0, 32'ha000_03f8, 32'd0, 8'h00, 2'b00, 32'h0000_0041, 1};
        tbl[11] = '{1'b0, 32'h8000_0004, 32'd0, 8'h00, 2'b00, 32'h7fff_fffb, 0};
        tbl[12] = '{1'b0, 32'ha000_03f4, 32'd0, 8'h00, 2'b11, 32'h0000_0000, -1};
        tbl[13] = '{1'b0, 32'h7fff_fffc, 32'd0, 8'h00, 2'b11, 32'h0000_0000, -1};

        // reset state: requests pending on every master channel must not leak out
        m_araddr = 32'h8000_0000; m_arvalid = 1'b1; m_awaddr = 32'ha000_03f8;
        m_awvalid = 1'b1; m_wvalid = 1'b1; m_rready = 1'b1; m_bready = 1'b1; m_wdata = 32'h55;
        repeat (3) @(negedge clk);
        chk("rst_handshakes", hs_vec(), 32'd0);
        chk("rst_rdata", m_rdata, 32'd0);
        chk("rst_resps", {28'd0, m_rresp, m_bresp}, 32'd0);
        chk("rst_s0_araddr", s0_araddr, 32'd0);
        chk("rst_s1_wdata", s1_wdata, 32'd0);
        m_arvalid = 1'b0; m_awvalid = 1'b0; m_wvalid = 1'b0; m_rready = 1'b0; m_bready = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;

        // directed vectors, deterministic slaves (always ready, zero latency)
        for (int i = 0; i < 14; i++) begin
            v0 = vc0; v1 = vc1;
            if (tbl[i].wr) begin
                do_write(tbl[i].addr, tbl[i].wdata, tbl[i].bytes, 1'b0, r, lat);
                ref_write(tbl[i].addr, tbl[i].wdata, er);
                chk($sformatf("vec%0d_bresp", i), 32'(r), 32'(tbl[i].resp));
                if (tbl[i].slave >= 0) begin
                    chk($sformatf("vec%0d_waddr", i), last_wa[tbl[i].slave], tbl[i].addr);
                    chk($sformatf("vec%0d_wdata", i), last_wd[tbl[i].slave], tbl[i].wdata);
                    chk($sformatf("vec%0d_bytes", i), 32'(last_wb[tbl[i].slave]), 32'(tbl[i].bytes));
                end
            end else begin
                do_read(tbl[i].addr, 1'b0, d, r, lat);
                chk($sformatf("vec%0d_rresp", i), 32'(r), 32'(tbl[i].resp));
                chk($sformatf("vec%0d_rdata", i), d, tbl[i].rdata);
            end
            chk($sformatf("vec%0d_decode_latency", i), 32'(lat), 32'd2);
            chk($sformatf("vec%0d_s0_active", i), 32'((vc0 - v0) != 0), 32'(tbl[i].slave == 0));
            chk($sformatf("vec%0d_s1_active", i), 32'((vc1 - v1) != 0), 32'(tbl[i].slave == 1));
        end

        // decode error read with the master stalling R for three cycles
        v0 = vc0; v1 = vc1;
        m_araddr = 32'h0000_1000; m_arvalid = 1'b1; m_rready = 1'b0;
        @(negedge clk); chk("err_idle_arready", 32'(m_arready), 32'd0);
        @(negedge clk); chk("err_arready_pulse", 32'(m_arready), 32'd1);
        @(posedge clk); #1 m_arvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("err_arready_low", 32'(m_arready), 32'd0);
            chk("err_rvalid_held", 32'(m_rvalid), 32'd1);
            chk("err_rresp", 32'(m_rresp), 32'd3);
            chk("err_rdata", m_rdata, 32'd0);
        end
        m_rready = 1'b1;
        @(posedge clk); #1 m_rready = 1'b0;
        @(negedge clk); chk("err_rvalid_done", 32'(m_rvalid), 32'd0);
        chk("err_no_slave_activity", 32'((vc0 - v0) + (vc1 - v1)), 32'd0);
        @(posedge clk); #1;

        // simultaneous read and write to the same SRAM address: read first, one IDLE gap
        ref_read(32'h8000_0000, ed, er);
        m_araddr = 32'h8000_0000; m_awaddr = 32'h8000_0000; m_wdata = 32'h1357_9bdf; m_bytes = 8'h0f;
        m_arvalid = 1'b1; m_awvalid = 1'b1; m_wvalid = 1'b1; m_rready = 1'b1; m_bready = 1'b1;
        @(negedge clk);
        chk("both_idle_s0_arvalid", 32'(s0_arvalid), 32'd0);
        @(negedge clk);
        chk("both_rd_s0_arvalid", 32'(s0_arvalid), 32'd1);
        chk("both_rd_s0_awvalid", 32'(s0_awvalid), 32'd0);
        chk("both_rd_arready", 32'(m_arready), 32'd1);
        @(posedge clk); #1 m_arvalid = 1'b0;
        @(negedge clk);
        chk("both_rvalid", 32'(m_rvalid), 32'd1);
        chk("both_rdata", m_rdata, ed);
        chk("both_rresp", 32'(m_rresp), 32'(er));
        @(negedge clk);
        chk("both_gap_s0_awvalid", 32'(s0_awvalid), 32'd0);
        chk("both_gap_awready", 32'(m_awready), 32'd0);
        @(negedge clk);
        chk("both_wr_s0_awvalid", 32'(s0_awvalid), 32'd1);
        chk("both_wr_s0_wvalid", 32'(s0_wvalid), 32'd1);
        chk("both_wr_awready", 32'(m_awready), 32'd1);
        chk("both_wr_s1_quiet", {31'd0, s1_awvalid | s1_wvalid}, 32'd0);
        @(posedge clk); #1 m_awvalid = 1'b0; m_wvalid = 1'b0;
        ref_write(32'h8000_0000, 32'h1357_9bdf, er);
        @(negedge clk);
        chk("both_bvalid", 32'(m_bvalid), 32'd1);
        chk("both_bresp", 32'(m_bresp), 32'd0);
        @(posedge clk); #1 m_bready = 1'b0; m_rready = 1'b0;
        @(negedge clk);
        chk("both_bvalid_done", 32'(m_bvalid), 32'd0);
        @(posedge clk); #1;

        // reset while RD waits on a slow SRAM response
        lat_fix = 7;
        m_araddr = 32'h8000_0020; m_arvalid = 1'b1; m_rready = 1'b1;
        @(negedge clk); @(negedge clk);
        @(posedge clk); #1 m_arvalid = 1'b0;
        @(negedge clk);
        chk("rdwait_rvalid", 32'(m_rvalid), 32'd0);
        chk("rdwait_s0_rready", 32'(s0_rready), 32'd1);
        #2 reset = 1'b0;
        #1 chk("midrst_handshakes", hs_vec(), 32'd0);
        @(negedge clk);
        reset = 1'b1; m_rready = 1'b0; lat_fix = 0;
        @(posedge clk); #1;
        do_read(32'h8000_0020, 1'b0, d, r, lat);
        ref_read(32'h8000_0020, ed, er);
        chk("postrst_rdata", d, ed);
        chk("postrst_rresp", 32'(r), 32'(er));
        chk("postrst_latency", 32'(lat), 32'd2);

        // randomized traffic with stalling slaves and master, against the reference model
        rnd_mode = 1'b1;
        for (int i = 0; i < 200; i++) begin
            cls = $urandom_range(0, 6);
            case (cls)
                0: a = 32'ha000_03f8;
                1: a = 32'ha000_03fc;
                2: a = 32'h8000_0000 + 32'($urandom_range(0, 31)) * 4;
                3: a = 32'h87ff_ff80 + 32'($urandom_range(0, 31)) * 4;
                4: begin
                    t = $urandom_range(0, 3);
                    a = (t == 0) ? 32'ha000_03f0 : (t == 1) ? 32'ha000_03f4 :
                        (t == 2) ? 32'ha000_0400 : 32'ha000_0404;
                end
                5: a = 32'h8800_0000 + 32'($urandom_range(0, 3)) * 4;
                default: begin
                    a = $urandom;
                    while (ref_target(a) >= 0) a = $urandom;
                end
            endcase
            wr = 1'($urandom_range(0, 1));
            t = ref_target(a);
            v0 = vc0; v1 = vc1;
            if (wr) begin
                wd = $urandom; be = 8'($urandom);
                do_write(a, wd, be, 1'b1, r, lat);
                ref_write(a, wd, er);
                chk("rnd_bresp", 32'(r), 32'(er));
            end else begin
                do_read(a, 1'b1, d, r, lat);
                ref_read(a, ed, er);
                chk("rnd_rresp", 32'(r), 32'(er));
                chk("rnd_rdata", d, ed);
            end
            chk("rnd_s0_active", 32'((vc0 - v0) != 0), 32'(t == 0));
            chk("rnd_s1_active", 32'((vc1 - v1) != 0), 32'(t == 1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
